// File: rtl/systolic_feed_controller.sv
// Feeds one tile of input vectors into the systolic skew buffer and then flushes it with zero vectors.
// Latency: setup_en/setup_data follow the accepted input in the same cycle; done pulses one cycle after the last EN.
// Backpressure: array_ready low stalls everything (no EN, no accept, counters and lane mask hold); in_ready = array_ready in LOAD.
//
// Ports:
//   CLK, SYNC_RST        clock, synchronous active-high reset
//   start, cfg_len       tile request and its vector count (sampled only in IDLE, clamped to MAX_LEN)
//   busy, done           high in LOAD/DRAIN; one-cycle completion pulse
//   in_valid/in_ready    input vector handshake, in_data lane i feeds skew row i
//   array_ready          downstream PE array may advance
//   setup_en/setup_data  skew buffer EN and Inputs
//   lane_valid           per-lane mask of real (non-flush) data at the skew output
//   vec_count            vectors accepted in the current tile
//   stall_cycles         LOAD/DRAIN cycles without EN; present only when FEED_PERF_CNT_EN is defined, else 0
module systolic_feed_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int SA_LENGTH  = 256,
    parameter int MAX_LEN    = 1024,
    parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                                         CLK,
    input  logic                                         SYNC_RST,
    input  logic                                         start,
    input  logic [LEN_W-1:0]                             cfg_len,
    output logic                                         busy,
    output logic                                         done,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic signed [SA_LENGTH-1:0][DATA_WIDTH-1:0]  in_data,
    input  logic                                         array_ready,
    output logic                                         setup_en,
    output logic signed [SA_LENGTH-1:0][DATA_WIDTH-1:0]  setup_data,
    output logic [SA_LENGTH-1:0]                         lane_valid,
    output logic [LEN_W-1:0]                             vec_count,
    output logic [31:0]                                  stall_cycles
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    localparam int                 DRN_W      = (SA_LENGTH > 1) ? $clog2(SA_LENGTH) : 1;
    // Drain ends on the (SA_LENGTH-1)th EN cycle, i.e. when the counter shows SA_LENGTH-2.
    localparam logic [DRN_W-1:0]   DRAIN_LAST = DRN_W'((SA_LENGTH > 1) ? SA_LENGTH - 2 : 0);
    localparam logic [LEN_W-1:0]   LEN_MAX    = LEN_W'(MAX_LEN);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  vec_count_q, vec_count_d;
    logic [DRN_W-1:0]  drain_q, drain_d;

    logic              accept;
    logic              start_acc;
    logic              last_vec;
    logic [LEN_W-1:0]  cfg_len_clamped;

    assign start_acc       = (state_q == S_IDLE) && start;
    assign last_vec        = (vec_count_q == len_q - LEN_W'(1));
    assign cfg_len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

    // State register
    always_ff @(posedge CLK) begin
        if (SYNC_RST) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = (cfg_len == '0) ? S_DONE : S_LOAD;
            S_LOAD:  if (accept && last_vec) state_d = (SA_LENGTH == 1) ? S_DONE : S_DRAIN;
            S_DRAIN: if (array_ready && drain_q == DRAIN_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready   = 1'b0;
        accept     = 1'b0;
        setup_en   = 1'b0;
        setup_data = '0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = array_ready;
                accept   = in_valid && array_ready;
                setup_en = accept;
                if (accept) setup_data = in_data;
            end
            S_DRAIN: begin
                busy     = 1'b1;
                setup_en = array_ready;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Tile length, accepted-vector count and drain count
    always_comb begin
        len_d       = len_q;
        vec_count_d = vec_count_q;
        drain_d     = drain_q;
        if (start_acc) begin
            len_d       = cfg_len_clamped;
            vec_count_d = '0;
            drain_d     = '0;
        end
        if (accept) vec_count_d = vec_count_q + LEN_W'(1);
        if (state_q == S_DRAIN && array_ready)
            drain_d = (drain_q == DRAIN_LAST) ? '0 : drain_q + DRN_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            len_q       <= '0;
            vec_count_q <= '0;
            drain_q     <= '0;
        end else begin
            len_q       <= len_d;
            vec_count_q <= vec_count_d;
            drain_q     <= drain_d;
        end
    end

    assign vec_count = vec_count_q;

    // Lane mask: lane i is delayed by i EN cycles, exactly like the skew rows.
    generate
        if (SA_LENGTH > 1) begin : g_skew
            logic [SA_LENGTH-1:1] v_q, v_d;

            always_comb begin
                v_d = v_q;
                if (setup_en) begin
                    v_d[1] = accept;
                    for (int i = 2; i < SA_LENGTH; i++) v_d[i] = v_q[i-1];
                end
            end

            always_ff @(posedge CLK) begin
                if (SYNC_RST) v_q <= '0;
                else          v_q <= v_d;
            end

            assign lane_valid = {v_q, accept};
        end else begin : g_noskew
            assign lane_valid = accept;
        end
    endgenerate

`ifdef FEED_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_acc)
            stall_d = '0;
        else if (busy && !setup_en && stall_q != '1)
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (SYNC_RST) stall_q <= '0;
        else          stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_feed_controller.sv
module tb_systolic_feed_controller;

    logic              clk;
    logic              sync_rst;
    logic              start;
    logic [2:0]        cfg_len;
    logic              in_valid;
    logic [3:0][7:0]   in_data;
    logic              array_ready;

    // SA_LENGTH=4 instance
    logic              busy, done, in_ready, setup_en;
    logic [3:0][7:0]   setup_data;
    logic [3:0]        lane_valid;
    logic [2:0]        vec_count;
    logic [31:0]       stall_cycles;

    // SA_LENGTH=1 instance, sharing the control stimulus
    logic              u1_busy, u1_done, u1_in_ready, u1_setup_en;
    logic [0:0][7:0]   u1_in_data;
    logic [0:0][7:0]   u1_setup_data;
    logic [0:0]        u1_lane_valid;
    logic [2:0]        u1_vec_count;
    logic [31:0]       u1_stall_cycles;

    assign u1_in_data[0] = in_data[0];

    systolic_feed_controller #(.DATA_WIDTH(8), .SA_LENGTH(4), .MAX_LEN(6)) u4 (
        .CLK(clk), .SYNC_RST(sync_rst), .start(start), .cfg_len(cfg_len),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .array_ready(array_ready), .setup_en(setup_en),
        .setup_data(setup_data), .lane_valid(lane_valid), .vec_count(vec_count),
        .stall_cycles(stall_cycles)
    );

    systolic_feed_controller #(.DATA_WIDTH(8), .SA_LENGTH(1), .MAX_LEN(6)) u1 (
        .CLK(clk), .SYNC_RST(sync_rst), .start(start), .cfg_len(cfg_len),
        .busy(u1_busy), .done(u1_done), .in_valid(in_valid), .in_ready(u1_in_ready),
        .in_data(u1_in_data), .array_ready(array_ready), .setup_en(u1_setup_en),
        .setup_data(u1_setup_data), .lane_valid(u1_lane_valid), .vec_count(u1_vec_count),
        .stall_cycles(u1_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    int          vidx;
    bit          pending;
    int          c;
    logic [15:0] en_m, done_m, busy_m;
    logic [15:0] lv_m [4];
    logic [15:0] u1_en_m, u1_done_m, u1_busy_m, u1_lv_m;
    logic [31:0] exp_stall2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] make_vec(input int k);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(128 + k*4 + i);
        return v;
    endfunction

    task automatic tile_begin();
        exp_q.delete();
        vidx = 0; pending = 0; c = 0;
        en_m = '0; done_m = '0; busy_m = '0;
        for (int i = 0; i < 4; i++) lv_m[i] = '0;
        u1_en_m = '0; u1_done_m = '0; u1_busy_m = '0; u1_lv_m = '0;
    endtask

    // One clock cycle: drive, settle, record/score, advance to just after the next edge.
    task automatic cyc(input logic st, input logic [2:0] len, input logic iv,
                       input logic ar, input logic rst);
        logic [31:0] exp_v;
        start = st; cfg_len = len; in_valid = iv; array_ready = ar; sync_rst = rst;
        if (iv && !pending) begin
            exp_q.push_back(make_vec(vidx));
            pending = 1;
        end
        in_data = iv ? make_vec(vidx) : '0;
        #2;
        if (c < 16) begin
            en_m[c] = setup_en; done_m[c] = done; busy_m[c] = busy;
            for (int i = 0; i < 4; i++) lv_m[i][c] = lane_valid[i];
            u1_en_m[c] = u1_setup_en; u1_done_m[c] = u1_done;
            u1_busy_m[c] = u1_busy; u1_lv_m[c] = u1_lane_valid[0];
        end
        if (u1_setup_en)
            chk("u1_data", 32'(u1_setup_data), make_vec(vidx) & 32'hFF);
        if (setup_en && in_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_v = exp_q.pop_front();
                chk("load_data", setup_data, exp_v);
            end
            vidx++;
            pending = 0;
        end else if (setup_en) begin
            chk("drain_zero", setup_data, 32'd0);
        end else if (setup_data !== '0) begin
            chk("idle_data_zero", setup_data, 32'd0);
        end
        c++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic(input string nm);
        tile_begin();
        for (int k = 0; k < 10; k++) cyc(k == 0, 3'd4, 1'b1, 1'b1, 1'b0);
        chk({nm, "_en"},   32'(en_m),     32'h00FE);
        chk({nm, "_lv0"},  32'(lv_m[0]),  32'h001E);
        chk({nm, "_lv1"},  32'(lv_m[1]),  32'h003C);
        chk({nm, "_lv2"},  32'(lv_m[2]),  32'h0078);
        chk({nm, "_lv3"},  32'(lv_m[3]),  32'h00F0);
        chk({nm, "_done"}, 32'(done_m),   32'h0100);
        chk({nm, "_busy"}, 32'(busy_m),   32'h00FE);
        chk({nm, "_vcnt"}, 32'(vec_count), 32'd4);
        chk({nm, "_lv_end"}, 32'(lane_valid), 32'd0);
        chk({nm, "_stall"}, stall_cycles, 32'd0);
    endtask

    initial begin
`ifdef FEED_PERF_CNT_EN
        exp_stall2 = 32'd2;
`else
        exp_stall2 = 32'd0;
`endif
        sync_rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0;
        in_data = '0; array_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_vcnt", 32'(vec_count), 32'd0);
        chk("rst_lv", 32'(lane_valid), 32'd0);
        chk("rst_en", 32'(setup_en), 32'd0);
        chk("rst_stall", stall_cycles, 32'd0);
        sync_rst = 1'b0;

        // Basic 4-vector tile
        test_basic("t1");

        // array_ready low in cycles 2-3
        tile_begin();
        for (int k = 0; k < 12; k++) cyc(k == 0, 3'd4, 1'b1, !(k == 2 || k == 3), 1'b0);
        chk("t2_en",   32'(en_m),    32'h03F2);
        chk("t2_lv0",  32'(lv_m[0]), 32'h0072);
        chk("t2_lv1",  32'(lv_m[1]), 32'h00FC);
        chk("t2_lv2",  32'(lv_m[2]), 32'h01E0);
        chk("t2_lv3",  32'(lv_m[3]), 32'h03C0);
        chk("t2_done", 32'(done_m),  32'h0400);
        chk("t2_busy", 32'(busy_m),  32'h03FE);
        chk("t2_stall", stall_cycles, exp_stall2);

        // Zero-length tile
        tile_begin();
        for (int k = 0; k < 4; k++) cyc(k == 0, 3'd0, 1'b1, 1'b1, 1'b0);
        chk("t3_en",   32'(en_m),   32'h0000);
        chk("t3_done", 32'(done_m), 32'h0002);
        chk("t3_busy", 32'(busy_m), 32'h0000);
        chk("t3_vcnt", 32'(vec_count), 32'd0);

        // Reset in cycle 3 aborts the tile
        tile_begin();
        for (int k = 0; k < 9; k++) cyc(k == 0, 3'd4, 1'b1, 1'b1, k == 3);
        chk("t4_en",   32'(en_m),   32'h000E);
        chk("t4_busy", 32'(busy_m), 32'h000E);
        chk("t4_done", 32'(done_m), 32'h0000);
        chk("t4_lv_c4", 32'({lv_m[3][4], lv_m[2][4], lv_m[1][4], lv_m[0][4]}), 32'd0);
        test_basic("t4b");

        // start during LOAD with cfg_len=7 is ignored
        tile_begin();
        for (int k = 0; k < 10; k++) cyc(k == 0 || k == 2, (k == 2) ? 3'd7 : 3'd4, 1'b1, 1'b1, 1'b0);
        chk("t5_en",   32'(en_m),   32'h00FE);
        chk("t5_done", 32'(done_m), 32'h0100);
        chk("t5_vcnt", 32'(vec_count), 32'd4);

        // cfg_len=7 above MAX_LEN=6 is clamped
        tile_begin();
        for (int k = 0; k < 12; k++) cyc(k == 0, 3'd7, 1'b1, 1'b1, 1'b0);
        chk("t6_en",   32'(en_m),   32'h03FE);
        chk("t6_done", 32'(done_m), 32'h0400);
        chk("t6_vcnt", 32'(vec_count), 32'd6);

        // 3-vector tile: SA_LENGTH=1 has no drain, SA_LENGTH=4 drains 3 cycles
        tile_begin();
        for (int k = 0; k < 9; k++) cyc(k == 0, 3'd3, 1'b1, 1'b1, 1'b0);
        chk("t7_u1_en",   32'(u1_en_m),   32'h000E);
        chk("t7_u1_done", 32'(u1_done_m), 32'h0010);
        chk("t7_u1_busy", 32'(u1_busy_m), 32'h000E);
        chk("t7_u1_lv0",  32'(u1_lv_m),   32'h000E);
        chk("t7_u1_vcnt", 32'(u1_vec_count), 32'd3);
        chk("t7_u4_en",   32'(en_m),   32'h007E);
        chk("t7_u4_done", 32'(done_m), 32'h0080);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
